cpu_phase_sequencer: RTL and testbench

//  Sequences the CPU control phases FETCH/EXEC1/EXEC2/EXEC3.
//  The instruction decoder consumes these phase strobes and returns extra/extra2, which set instruction length.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/retire_counter.sv | 28 ++
 rtl/cpu_phase_sequencer.sv | 144 ++++++++++++++
 tb/tb_cpu_phase_sequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU control path: the phase encoding used by the
// sequencer FSM and the default instruction width.
package cpu_pkg;

    localparam int IW = 16;

    typedef enum logic [2:0] {
        PH_FETCH = 3'd0,
        PH_EXEC1 = 3'd1,
        PH_EXEC2 = 3'd2,
        PH_EXEC3 = 3'd3,
        PH_HALT  = 3'd4
    } phase_t;

endpackage

// File: rtl/retire_counter.sv
// Retired-instruction counter: counts instruction boundaries.
// It wraps modulo 2^CNT_W and holds while the pipeline is stalled.
module retire_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic             i_stall,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    // Count one per completed instruction; wraps naturally with no saturation.
    always_ff @(posedge clk) begin
        // NOTE: state is only ever updated with non-blocking assignments so
        // every flop samples the pre-edge values of the others.
        if (reset) begin
            r_count <= '0;
        end else if (i_en && !i_stall) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/cpu_phase_sequencer.sv
// CPU phase sequencer: steps FETCH/EXEC1/EXEC2/EXEC3 and latches the
// instruction register. It adds run/halt/single-step control, stall hold
// and a retired-instruction counter.
// Phase strobes come straight from flops, so no input reaches them combinationally.
module cpu_phase_sequencer #(
    parameter int unsigned IW        = cpu_pkg::IW,
    parameter int unsigned CNT_W     = 16,
    parameter bit          RESET_RUN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IW-1:0]    rom_q,
    input  logic             extra,
    input  logic             extra2,
    input  logic             stall,
    input  logic             run,
    input  logic             halt_req,
    input  logic             step_req,
    output logic [IW-1:0]    instr,
    output logic             fetch,
    output logic             exec1,
    output logic             exec2,
    output logic             exec3,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    import cpu_pkg::*;

    localparam phase_t RESET_STATE = RESET_RUN ? PH_FETCH : PH_HALT;

    phase_t          r_state;
    logic [IW-1:0]   r_instr;
    logic            r_step_pending;
    logic            r_fetch;
    logic            r_exec1;
    logic            r_exec2;
    logic            r_exec3;
    logic            r_halted;

    phase_t          w_next;
    logic            w_latch_ir;
    logic            w_boundary;
    logic            w_set_pending;

    // Next-phase decision; the instruction boundary picks HALT or FETCH.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        w_next        = r_state;
        w_latch_ir    = 1'b0;
        w_boundary    = 1'b0;
        w_set_pending = 1'b0;

        case (r_state)
            PH_HALT: begin
                // halt_req wins over run and step_req; stall has no effect here.
                if (!halt_req) begin
                    if (run) begin
                        w_next = PH_FETCH;
                    end else if (step_req) begin
                        w_next        = PH_FETCH;
                        w_set_pending = 1'b1;
                    end
                end
            end
            PH_FETCH: begin
                if (!stall) begin
                    w_next     = PH_EXEC1;
                    w_latch_ir = 1'b1;
                end
            end
            PH_EXEC1: begin
                if (!stall) begin
                    if (extra) w_next = PH_EXEC2;
                    else       w_boundary = 1'b1;
                end
            end
            PH_EXEC2: begin
                if (!stall) begin
                    if (extra2) w_next = PH_EXEC3;
                    else        w_boundary = 1'b1;
                end
            end
            PH_EXEC3: begin
                if (!stall) w_boundary = 1'b1;
            end
            default: begin
                // Unused encodings recover to FETCH on the next edge.
                w_next = PH_FETCH;
            end
        endcase

        if (w_boundary) begin
            w_next = (halt_req || !run || r_step_pending) ? PH_HALT : PH_FETCH;
        end
    end

    // State, IR, step bookkeeping and one-hot strobes, all registered together.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= RESET_STATE;
            r_instr        <= '0;
            r_step_pending <= 1'b0;
            r_fetch        <= (RESET_STATE == PH_FETCH);
            r_exec1        <= 1'b0;
            r_exec2        <= 1'b0;
            r_exec3        <= 1'b0;
            r_halted       <= (RESET_STATE == PH_HALT);
        end else begin
            r_state <= w_next;
            if (w_latch_ir) begin
                r_instr <= rom_q;
            end
            if (w_set_pending) begin
                r_step_pending <= 1'b1;
            end else if (w_boundary) begin
                r_step_pending <= 1'b0;
            end
            r_fetch  <= (w_next == PH_FETCH);
            r_exec1  <= (w_next == PH_EXEC1);
            r_exec2  <= (w_next == PH_EXEC2);
            r_exec3  <= (w_next == PH_EXEC3);
            r_halted <= (w_next == PH_HALT);
        end
    end

    retire_counter #(
        .CNT_W (CNT_W)
    ) u_retire_counter (
        .clk     (clk),
        .reset   (reset),
        .i_en    (w_boundary),
        .i_stall (stall),
        .o_count (retired)
    );

    assign instr  = r_instr;
    assign fetch  = r_fetch;
    assign exec1  = r_exec1;
    assign exec2  = r_exec2;
    assign exec3  = r_exec3;
    assign halted = r_halted;

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// Testbench for cpu_phase_sequencer: directed vector table, hand-written
// corner sequences, a small-counter/halt-on-reset instance for wrap, and
// randomized traffic against an instruction-level reference model.
module tb_cpu_phase_sequencer;

    localparam logic [4:0] PF = 5'b00001;
    localparam logic [4:0] P1 = 5'b00010;
    localparam logic [4:0] P2 = 5'b00100;
    localparam logic [4:0] P3 = 5'b01000;
    localparam logic [4:0] PH = 5'b10000;

    logic        clk = 1'b0;
    logic        reset, extra, extra2, stall, run, halt_req, step_req;
    logic [15:0] rom_q;
    logic [15:0] instr;
    logic        fetch, exec1, exec2, exec3, halted;
    logic [15:0] retired;

    // Second instance: 4-bit counter, leaves reset halted.
    logic        rst2, run2, c0;
    logic [15:0] c16;
    logic [15:0] instr2;
    logic        f2, e1_2, e2_2, e3_2, h2;
    logic [3:0]  ret2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cpu_phase_sequencer dut (
        .clk(clk), .reset(reset), .rom_q(rom_q), .extra(extra), .extra2(extra2),
        .stall(stall), .run(run), .halt_req(halt_req), .step_req(step_req),
        .instr(instr), .fetch(fetch), .exec1(exec1), .exec2(exec2), .exec3(exec3),
        .halted(halted), .retired(retired)
    );

    cpu_phase_sequencer #(.IW(16), .CNT_W(4), .RESET_RUN(1'b0)) dut2 (
        .clk(clk), .reset(rst2), .rom_q(c16), .extra(c0), .extra2(c0),
        .stall(c0), .run(run2), .halt_req(c0), .step_req(c0),
        .instr(instr2), .fetch(f2), .exec1(e1_2), .exec2(e2_2), .exec3(e3_2),
        .halted(h2), .retired(ret2)
    );

    wire [4:0] ph  = {halted, exec3, exec2, exec1, fetch};
    wire [4:0] ph2 = {h2, e3_2, e2_2, e1_2, f2};

    // ---------------- reference model (instruction level) ----------------
    // m_pos counts cycles into the current instruction (0 = fetch cycle).
    bit          m_halted;
    int          m_pos;
    logic [15:0] m_instr;
    logic [15:0] m_ret;
    bit          m_pend;

    task automatic model_step();
        bit more;
        if (reset) begin
            m_halted = 1'b0; m_pos = 0; m_instr = '0; m_ret = '0; m_pend = 1'b0;
        end else if (m_halted) begin
            if (!halt_req && (run || step_req)) begin
                m_halted = 1'b0;
                m_pos    = 0;
                m_pend   = !run;
            end
        end else if (!stall) begin
            more = (m_pos == 0) || (m_pos == 1 && extra) || (m_pos == 2 && extra2);
            if (m_pos == 0) m_instr = rom_q;
            if (more) begin
                m_pos = m_pos + 1;
            end else begin
                m_ret    = m_ret + 16'd1;
                m_halted = halt_req || !run || m_pend;
                m_pend   = 1'b0;
                m_pos    = 0;
            end
        end
    endtask

    function automatic logic [4:0] model_ph();
        return m_halted ? PH : 5'(1 << m_pos);
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [5:0]  fl;    // {run, halt_req, step_req, stall, extra, extra2}
        logic [15:0] rom;
        logic [4:0]  ph;
        logic [15:0] ins;
        logic [15:0] ret;
    } vec_t;

    vec_t tbl[31];

    function automatic vec_t v(input logic [5:0] fl, input logic [15:0] rom,
                               input logic [4:0] p, input logic [15:0] ins,
                               input logic [15:0] ret);
        vec_t r;
        r.fl = fl; r.rom = rom; r.ph = p; r.ins = ins; r.ret = ret;
        return r;
    endfunction

    initial begin
        tbl[0]  = v(6'b100000, 16'h1111, P1, 16'h1111, 16'd0);
        tbl[1]  = v(6'b100000, 16'hDEAD, PF, 16'h1111, 16'd1);
        tbl[2]  = v(6'b100000, 16'h2222, P1, 16'h2222, 16'd1);
        tbl[3]  = v(6'b100000, 16'hDEAD, PF, 16'h2222, 16'd2);
        tbl[4]  = v(6'b100000, 16'h3333, P1, 16'h3333, 16'd2);
        tbl[5]  = v(6'b100000, 16'hDEAD, PF, 16'h3333, 16'd3);
        tbl[6]  = v(6'b100011, 16'h4444, P1, 16'h4444, 16'd3);
        tbl[7]  = v(6'b100011, 16'hDEAD, P2, 16'h4444, 16'd3);
        tbl[8]  = v(6'b100011, 16'hDEAD, P3, 16'h4444, 16'd3);
        tbl[9]  = v(6'b100011, 16'hDEAD, PF, 16'h4444, 16'd4);
        tbl[10] = v(6'b100010, 16'h5555, P1, 16'h5555, 16'd4);
        tbl[11] = v(6'b100010, 16'hDEAD, P2, 16'h5555, 16'd4);
        tbl[12] = v(6'b100110, 16'hDEAD, P2, 16'h5555, 16'd4);
        tbl[13] = v(6'b100110, 16'hDEAD, P2, 16'h5555, 16'd4);
        tbl[14] = v(6'b100110, 16'hDEAD, P2, 16'h5555, 16'd4);
        tbl[15] = v(6'b100010, 16'hDEAD, PF, 16'h5555, 16'd5);
        tbl[16] = v(6'b100110, 16'h6666, PF, 16'h5555, 16'd5);
        tbl[17] = v(6'b100010, 16'h7777, P1, 16'h7777, 16'd5);
        tbl[18] = v(6'b110010, 16'hDEAD, P2, 16'h7777, 16'd5);
        tbl[19] = v(6'b110010, 16'hDEAD, PH, 16'h7777, 16'd6);
        tbl[20] = v(6'b110000, 16'hDEAD, PH, 16'h7777, 16'd6);
        tbl[21] = v(6'b000000, 16'hDEAD, PH, 16'h7777, 16'd6);
        tbl[22] = v(6'b001011, 16'hDEAD, PF, 16'h7777, 16'd6);
        tbl[23] = v(6'b000011, 16'h8888, P1, 16'h8888, 16'd6);
        tbl[24] = v(6'b000011, 16'hDEAD, P2, 16'h8888, 16'd6);
        tbl[25] = v(6'b000011, 16'hDEAD, P3, 16'h8888, 16'd6);
        tbl[26] = v(6'b000011, 16'hDEAD, PH, 16'h8888, 16'd7);
        tbl[27] = v(6'b011100, 16'hDEAD, PH, 16'h8888, 16'd7);
        tbl[28] = v(6'b100100, 16'hDEAD, PF, 16'h8888, 16'd7);
        tbl[29] = v(6'b100001, 16'h9999, P1, 16'h9999, 16'd7);
        tbl[30] = v(6'b100001, 16'hDEAD, PF, 16'h9999, 16'd8);

        // Hold both instances in reset.
        reset = 1'b1; rst2 = 1'b1; run2 = 1'b0; c0 = 1'b0; c16 = '0;
        {run, halt_req, step_req, stall, extra, extra2} = 6'b100000;
        rom_q = 16'hDEAD;
        tick(); tick();
        check("reset_phase", ph, PF);
        check("reset_instr", instr, 16'h0);
        check("reset_retired", retired, 16'h0);
        check("reset_halt_phase", ph2, PH);

        // Instance 2: stays halted with run low, then free-runs and wraps 4 bits.
        rst2 = 1'b0;
        tick();
        check("halt_idle_phase", ph2, PH);
        run2 = 1'b1;
        tick();
        check("halt_to_fetch", ph2, PF);
        for (int i = 0; i < 30; i++) tick();
        check("wrap_before", ret2, 4'hF);
        tick(); tick();
        check("wrap_after", ret2, 4'h0);
        check("wrap_phase", ph2, PF);

        // Directed table on the main instance.
        reset = 1'b0;
        for (int i = 0; i < 31; i++) begin
            {run, halt_req, step_req, stall, extra, extra2} = tbl[i].fl;
            rom_q = tbl[i].rom;
            tick();
            check($sformatf("tbl%0d_phase", i), ph, tbl[i].ph);
            check($sformatf("tbl%0d_instr", i), instr, tbl[i].ins);
            check($sformatf("tbl%0d_retired", i), retired, tbl[i].ret);
        end

        // Reset in the middle of EXEC3 aborts the instruction.
        {run, halt_req, step_req, stall, extra, extra2} = 6'b100011;
        rom_q = 16'hABCD;
        tick();
        rom_q = 16'hDEAD;
        tick(); tick();
        check("e3_before_reset", ph, P3);
        check("e3_instr", instr, 16'hABCD);
        reset = 1'b1;
        tick();
        check("abort_phase", ph, PF);
        check("abort_instr", instr, 16'h0);
        check("abort_retired", retired, 16'h0);

        // Randomized traffic against the model.
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            reset    = ($urandom_range(0, 199) == 0);
            run      = ($urandom_range(0, 7) != 0);
            halt_req = ($urandom_range(0, 15) == 0);
            step_req = ($urandom_range(0, 5) == 0);
            stall    = ($urandom_range(0, 4) == 0);
            extra    = 1'($urandom);
            extra2   = 1'($urandom);
            rom_q    = 16'($urandom);
            tick();
            check("rnd_phase", ph, model_ph());
            check("rnd_instr", instr, m_instr);
            check("rnd_retired", retired, m_ret);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
